// File: rtl/uart_pkg.sv
// UART shared constants and state encoding.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int OVS          = 16;
  localparam int BAUD_DIV_DEF = 651;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one s_tick every BAUD_DIV clocks.
// pre_tick flags that the next cycle carries a tick.
import uart_pkg::*;

module uart_baud_gen #(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic s_tick,
  output logic pre_tick
);

  localparam int W = cnt_w(BAUD_DIV);
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt + W'(1);
    if (clr || cnt == LAST) cnt_n = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_n;
  end

  assign s_tick   = (cnt == LAST);
  assign pre_tick = (cnt_n == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first,
// optional parity, stop bit(s); all outputs registered.
import uart_pkg::*;

module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] w_data,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int CW = cnt_w(SB_TICK > OVS ? SB_TICK : OVS);
  localparam int NW = cnt_w(DBIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic          ODD       = 1'(PARITY_ODD);

  uart_state_t     state, state_n;
  logic [CW-1:0]   s_cnt, s_cnt_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic            par, par_n;
  logic            tx_q, tx_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            clr;
  logic            s_tick;
  logic            pre_tick;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .s_tick  (s_tick),
    .pre_tick(pre_tick)
  );

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_n     = n;
    shreg_n = shreg;
    par_n   = par;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          shreg_n = w_data;
          par_n   = (^w_data) ^ ODD;
          clr     = 1'b1;
          s_cnt_n = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_n = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_cnt_n = s_cnt + CW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_n = '0;
            shreg_n = shreg >> 1;
            if (n == N_LAST)
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
            else
              n_n = n + NW'(1);
          end else begin
            s_cnt_n = s_cnt + CW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_n = '0;
            state_n = STOP;
          end else begin
            s_cnt_n = s_cnt + CW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            s_cnt_n = '0;
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE);
    // Look ahead one cycle so the registered pulse lines up
    // with the final stop tick, while the state is still STOP.
    done_n = (state_n == STOP) && (s_cnt_n == STOP_LAST)
           && pre_tick;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n      <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      s_cnt  <= s_cnt_n;
      n      <= n_n;
      shreg  <= shreg_n;
      par    <= par_n;
      tx_q   <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_DIV=4 (64 clocks/bit).
// u0: no parity, u1: even parity, u2: odd parity.
module tb_uart_tx;

  localparam int BITCLK = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] tx_start;
  logic [7:0] w_data [3];
  logic [2:0] tx;
  logic [2:0] tx_busy;
  logic [2:0] tx_done_tick;

  int vec_cnt = 0;
  int miscmp  = 0;

  always #5 clock = ~clock;

  uart_tx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4),
            .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clock(clock), .reset(reset), .tx_start(tx_start[0]),
    .w_data(w_data[0]), .tx(tx[0]), .tx_busy(tx_busy[0]),
    .tx_done_tick(tx_done_tick[0]));

  uart_tx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4),
            .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clock(clock), .reset(reset), .tx_start(tx_start[1]),
    .w_data(w_data[1]), .tx(tx[1]), .tx_busy(tx_busy[1]),
    .tx_done_tick(tx_done_tick[1]));

  uart_tx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4),
            .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clock(clock), .reset(reset), .tx_start(tx_start[2]),
    .w_data(w_data[2]), .tx(tx[2]), .tx_busy(tx_busy[2]),
    .tx_done_tick(tx_done_tick[2]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [10:0] exp;
    int         nbits;
    int         inj_at;
    logic [7:0] inj_data;
    bit         hold;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input int i, input logic [7:0] d);
    tx_start[i] = 1'b1;
    w_data[i]   = d;
    step();
  endtask

  // Entered just after the accept edge; exits one clock after
  // the done cycle, where the line must be idle.
  task automatic run_frame(input int i, input logic [10:0] exp,
                           input int nbits, input int inj_at,
                           input logic [7:0] inj_d, input bit hold,
                           input string tag);
    int done_n   = 0;
    int done_pos = -1;
    int busy_bad = 0;
    if (!hold) begin
      tx_start[i] = 1'b0;
      w_data[i]   = ~w_data[i];
    end
    for (int b = 0; b < nbits; b++) begin
      int errs = 0;
      for (int k = 0; k < BITCLK; k++) begin
        int j = b * BITCLK + k;
        if (tx[i] !== exp[b]) errs++;
        if (tx_busy[i] !== 1'b1) busy_bad++;
        if (tx_done_tick[i] === 1'b1) begin
          done_n++;
          done_pos = j;
        end
        if (inj_at >= 0 && j == inj_at) begin
          tx_start[i] = 1'b1;
          w_data[i]   = inj_d;
        end else if (inj_at >= 0 && j == inj_at + 1) begin
          tx_start[i] = 1'b0;
        end
        step();
      end
      chk($sformatf("%s bit%0d errs", tag, b), errs, 0);
    end
    chk({tag, " busy_low_cycles"}, busy_bad, 0);
    chk({tag, " done_count"}, done_n, 1);
    chk({tag, " done_pos"}, done_pos, nbits * BITCLK - 1);
    chk({tag, " idle tx"}, tx[i], 1);
    chk({tag, " idle busy"}, tx_busy[i], 0);
    chk({tag, " idle done"}, tx_done_tick[i], 0);
  endtask

  initial begin
    int dn;
    int txbad;

    vecs[0] = '{0, 8'hC3, {1'b1, 1'b1, 8'hC3, 1'b0}, 10, 200, 8'hA5, 1'b0};
    vecs[1] = '{0, 8'h55, {1'b1, 1'b1, 8'h55, 1'b0}, 10, -1, 8'h00, 1'b1};
    vecs[2] = '{0, 8'h55, {1'b1, 1'b1, 8'h55, 1'b0}, 10, -1, 8'h00, 1'b1};
    vecs[3] = '{0, 8'h55, {1'b1, 1'b1, 8'h55, 1'b0}, 10, -1, 8'h00, 1'b0};
    vecs[4] = '{1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 8'h00, 1'b0};
    vecs[5] = '{2, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 8'h00, 1'b0};
    vecs[6] = '{1, 8'hC3, {1'b1, 1'b0, 8'hC3, 1'b0}, 11, -1, 8'h00, 1'b0};
    vecs[7] = '{2, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 11, -1, 8'h00, 1'b0};

    reset    = 1'b1;
    tx_start = '0;
    for (int i = 0; i < 3; i++) w_data[i] = '0;

    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("reset%0d tx", c), tx, 3'b111);
      chk($sformatf("reset%0d busy", c), tx_busy, 3'b000);
      chk($sformatf("reset%0d done", c), tx_done_tick, 3'b000);
    end
    reset = 1'b0;
    txbad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (tx !== 3'b111 || tx_busy !== 3'b000) txbad++;
    end
    chk("idle_after_reset", txbad, 0);

    for (int v = 0; v < 8; v++) begin
      launch(vecs[v].inst, vecs[v].data);
      run_frame(vecs[v].inst, vecs[v].exp, vecs[v].nbits,
                vecs[v].inj_at, vecs[v].inj_data, vecs[v].hold,
                $sformatf("vec%0d", v));
    end

    // Abort a frame of zeros during data bit 3.
    launch(0, 8'h00);
    tx_start[0] = 1'b0;
    dn = 0;
    for (int j = 0; j < 280; j++) begin
      if (tx_done_tick[0] === 1'b1) dn++;
      step();
    end
    chk("abort pre tx", tx[0], 0);
    chk("abort pre busy", tx_busy[0], 1);
    reset = 1'b1;
    step();
    chk("abort tx", tx[0], 1);
    chk("abort busy", tx_busy[0], 0);
    chk("abort done", tx_done_tick[0], 0);
    step();
    reset = 1'b0;
    txbad = 0;
    for (int j = 0; j < 700; j++) begin
      if (tx_done_tick[0] === 1'b1) dn++;
      if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) txbad++;
      step();
    end
    chk("abort no_done", dn, 0);
    chk("abort line_idle", txbad, 0);

    launch(0, 8'h0F);
    run_frame(0, {1'b1, 1'b1, 8'h0F, 1'b0}, 10, -1, 8'h00, 1'b0,
              "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miscmp);
    $finish;
  end

endmodule
